// File: rtl/ysyx_22050854_pkg.sv
// Shared types and constants for the GPR write-back path: data width, register
// count and the write-back source identifier used by the arbiter.
package ysyx_22050854_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   gpr_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // x0 is hardwired to zero: it is never written and never tracked as busy
    function automatic logic is_x0(input gpr_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/ysyx_22050854_wb_arbiter_if.sv
// Bundle of the write-back arbiter's handshake, scoreboard query and register-file
// write signals. The slave side is the arbiter; the master side drives it.
interface ysyx_22050854_wb_arbiter_if;
    import ysyx_22050854_pkg::*;

    logic      exu_valid;
    logic      exu_ready;
    gpr_addr_t exu_rd;
    xlen_t     exu_data;

    logic      lsu_valid;
    logic      lsu_ready;
    gpr_addr_t lsu_rd;
    xlen_t     lsu_data;

    logic      issue_valid;
    gpr_addr_t issue_rd;
    logic      issue_ready;

    gpr_addr_t raddra;
    gpr_addr_t raddrb;
    logic      busy_a;
    logic      busy_b;

    logic      rf_wen;
    gpr_addr_t rf_waddr;
    xlen_t     rf_wdata;

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        input  raddra, raddrb,
        output exu_ready, lsu_ready, issue_ready,
        output busy_a, busy_b,
        output rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        output raddra, raddrb,
        input  exu_ready, lsu_ready, issue_ready,
        input  busy_a, busy_b,
        input  rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/ysyx_22050854_scoreboard.sv
// Per-register busy bits: set when a writer issues, cleared when its result reaches
// the register file. Three combinational read ports for the two sources and issue.
module ysyx_22050854_scoreboard
    import ysyx_22050854_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      set_en,
    input  gpr_addr_t set_addr,
    input  logic      clr_en,
    input  gpr_addr_t clr_addr,
    input  gpr_addr_t raddr_a,
    input  gpr_addr_t raddr_b,
    input  gpr_addr_t raddr_issue,
    output logic      busy_a,
    output logic      busy_b,
    output logic      busy_issue
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a new writer issuing on the same edge as the
    // old result retiring keeps the register marked pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && !is_x0(set_addr)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a     = !is_x0(raddr_a)     && busy_q[raddr_a];
    assign busy_b     = !is_x0(raddr_b)     && busy_q[raddr_b];
    assign busy_issue = !is_x0(raddr_issue) && busy_q[raddr_issue];

endmodule

// File: rtl/ysyx_22050854_wb_arbiter.sv
// GPR write-port arbiter: round-robin between EXU and LSU results, one registered
// write per cycle, plus the busy scoreboard IDU uses for RAW/WAW stalls.
module ysyx_22050854_wb_arbiter
    import ysyx_22050854_pkg::*;
(
    input logic                          clock,
    input logic                          reset,
    ysyx_22050854_wb_arbiter_if.slave    bus
);

    wb_src_e   last_grant;
    logic      exu_grant;
    logic      lsu_grant;
    logic      xfer;
    gpr_addr_t win_rd;
    xlen_t     win_data;

    logic      rf_wen_q;
    gpr_addr_t rf_waddr_q;
    xlen_t     rf_wdata_q;

    logic      busy_issue;
    logic      issue_ok;
    logic      issue_set;

    // Grants depend only on the valids and last_grant; nothing is accepted while
    // reset is high so a held result is not lost across the reset edge.
    always_comb begin
        exu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            if (bus.exu_valid && bus.lsu_valid) begin
                lsu_grant = (last_grant == WB_EXU);
                exu_grant = (last_grant == WB_LSU);
            end else begin
                exu_grant = bus.exu_valid;
                lsu_grant = bus.lsu_valid;
            end
        end
    end

    assign xfer     = exu_grant || lsu_grant;
    assign win_rd   = lsu_grant ? bus.lsu_rd   : bus.exu_rd;
    assign win_data = lsu_grant ? bus.lsu_data : bus.exu_data;

    assign bus.exu_ready = exu_grant;
    assign bus.lsu_ready = lsu_grant;

    // Write stage: an accepted result reaches the register file one cycle later;
    // results aimed at x0 finish the handshake but never assert the write enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            last_grant <= WB_EXU;
        end else begin
            rf_wen_q <= xfer && !is_x0(win_rd);
            if (xfer) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
                last_grant <= lsu_grant ? WB_LSU : WB_EXU;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    assign issue_ok        = is_x0(bus.issue_rd) || !busy_issue;
    assign issue_set       = bus.issue_valid && issue_ok;
    assign bus.issue_ready = issue_ok;

    ysyx_22050854_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .set_en      (issue_set),
        .set_addr    (bus.issue_rd),
        .clr_en      (rf_wen_q),
        .clr_addr    (rf_waddr_q),
        .raddr_a     (bus.raddra),
        .raddr_b     (bus.raddrb),
        .raddr_issue (bus.issue_rd),
        .busy_a      (bus.busy_a),
        .busy_b      (bus.busy_b),
        .busy_issue  (busy_issue)
    );

endmodule

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
// Directed bench for the write-back arbiter: expected register-file writes are queued
// as stimulus is issued and a negedge monitor retires them against rf_wen.
module tb_ysyx_22050854_wb_arbiter;
    import ysyx_22050854_pkg::*;

    typedef struct {
        gpr_addr_t addr;
        xlen_t     data;
    } wr_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    wr_t  exp_q[$];

    ysyx_22050854_wb_arbiter_if bus ();

    ysyx_22050854_wb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: each committed write must match the oldest queued expectation
    always @(negedge clock) begin
        if (bus.rf_wen === 1'b1 && reset === 1'b0) begin
            wr_t head;
            vectors = vectors + 1;
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("[TB] FAIL rf_write: got waddr=%0d wdata=%h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                head = exp_q.pop_front();
                if (bus.rf_waddr !== head.addr || bus.rf_wdata !== head.data) begin
                    miscompares = miscompares + 1;
                    $display("[TB] FAIL rf_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             bus.rf_waddr, bus.rf_wdata, head.addr, head.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expectWrite(input gpr_addr_t addr, input xlen_t data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic applyStimulus(input logic ev, input gpr_addr_t erd, input xlen_t ed,
                                 input logic lv, input gpr_addr_t lrd, input xlen_t ld,
                                 input logic iv, input gpr_addr_t ird,
                                 input gpr_addr_t ra, input gpr_addr_t rb);
        bus.exu_valid   = ev;
        bus.exu_rd      = erd;
        bus.exu_data    = ed;
        bus.lsu_valid   = lv;
        bus.lsu_rd      = lrd;
        bus.lsu_data    = ld;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.raddra      = ra;
        bus.raddrb      = rb;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
        end
    endtask

    task automatic idle(input gpr_addr_t ra, input gpr_addr_t rb);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, ra, rb);
    endtask

    initial begin
        xlen_t e_data;
        xlen_t l_data;
        vectors     = 0;
        miscompares = 0;

        // Reset held two cycles with both sources requesting
        reset = 1'b1;
        applyStimulus(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        tick();
        checkOutput("reset_rf_wen", bus.rf_wen, 1'b0);
        checkOutput("reset_exu_ready", bus.exu_ready, 1'b0);
        checkOutput("reset_lsu_ready", bus.lsu_ready, 1'b0);
        checkOutput("reset_busy_a", bus.busy_a, 1'b0);
        checkOutput("reset_busy_b", bus.busy_b, 1'b0);
        idle(5'd0, 5'd0);
        reset = 1'b0;
        tick();

        // Single EXU result for an issued x5
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd5, 5'd0);
        #1;
        checkOutput("exu_issue_ready", bus.issue_ready, 1'b1);
        checkOutput("exu_busy_before", bus.busy_a, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        expectWrite(5'd5, 64'hDEAD);
        #1;
        checkOutput("exu_ready", bus.exu_ready, 1'b1);
        checkOutput("exu_lsu_ready", bus.lsu_ready, 1'b0);
        checkOutput("exu_busy_pending", bus.busy_a, 1'b1);
        tick();
        idle(5'd5, 5'd0);
        #1;
        checkOutput("exu_rf_wen", bus.rf_wen, 1'b1);
        checkOutput("exu_busy_during_wen", bus.busy_a, 1'b1);
        tick();
        checkOutput("exu_busy_cleared", bus.busy_a, 1'b0);
        checkOutput("exu_rf_wen_off", bus.rf_wen, 1'b0);

        // Both valid for four cycles: LSU, EXU, LSU, EXU
        e_data = 64'hB000;
        l_data = 64'hA000;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd4, e_data, 1'b1, 5'd3, l_data, 1'b0, 5'd0, 5'd0, 5'd0);
            #1;
            if (i % 2 == 0) begin
                checkOutput("tie_lsu_grant", bus.lsu_ready, 1'b1);
                checkOutput("tie_exu_wait", bus.exu_ready, 1'b0);
                expectWrite(5'd3, l_data);
            end else begin
                checkOutput("tie_exu_grant", bus.exu_ready, 1'b1);
                checkOutput("tie_lsu_wait", bus.lsu_ready, 1'b0);
                expectWrite(5'd4, e_data);
            end
            if (i > 0) begin
                checkOutput("tie_no_bubble", bus.rf_wen, 1'b1);
            end
            tick();
            if (i % 2 == 0) l_data = l_data + 64'd1;
            else            e_data = e_data + 64'd1;
        end
        idle(5'd0, 5'd0);
        #1;
        checkOutput("tie_last_wen", bus.rf_wen, 1'b1);
        tick();

        // x0 destination: handshake completes, nothing written, never busy
        applyStimulus(1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("x0_exu_ready", bus.exu_ready, 1'b1);
        checkOutput("x0_issue_ready", bus.issue_ready, 1'b1);
        checkOutput("x0_busy_a", bus.busy_a, 1'b0);
        tick();
        idle(5'd0, 5'd0);
        #1;
        checkOutput("x0_rf_wen", bus.rf_wen, 1'b0);
        checkOutput("x0_busy_after", bus.busy_a, 1'b0);
        tick();

        // Unissued write to x7 retires on the same edge a new x7 writer issues
        applyStimulus(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd0);
        expectWrite(5'd7, 64'h77);
        #1;
        checkOutput("x7_exu_ready", bus.exu_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        #1;
        checkOutput("x7_rf_wen", bus.rf_wen, 1'b1);
        checkOutput("x7_issue_ready_free", bus.issue_ready, 1'b1);
        checkOutput("x7_busy_before", bus.busy_a, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7, 5'd0);
        #1;
        checkOutput("x7_set_wins", bus.busy_a, 1'b1);
        checkOutput("x7_issue_blocked", bus.issue_ready, 1'b0);
        tick();

        // Reset mid-operation: busy x10/x9, LSU grant, then reset with sources held
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 5'd10, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd10, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 5'd10, 5'd9);
        #1;
        checkOutput("rst_busy_a_set", bus.busy_a, 1'b1);
        checkOutput("rst_busy_b_set", bus.busy_b, 1'b1);
        checkOutput("rst_lsu_grant", bus.lsu_ready, 1'b1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 5'd11, 64'hE11, 1'b1, 5'd9, 64'hAA, 1'b0, 5'd0, 5'd10, 5'd9);
        #1;
        checkOutput("rst_no_lsu_ready", bus.lsu_ready, 1'b0);
        checkOutput("rst_no_exu_ready", bus.exu_ready, 1'b0);
        tick();
        reset = 1'b0;
        expectWrite(5'd9, 64'hAA);
        #1;
        checkOutput("rst_rf_wen_dropped", bus.rf_wen, 1'b0);
        checkOutput("rst_busy_a_clear", bus.busy_a, 1'b0);
        checkOutput("rst_busy_b_clear", bus.busy_b, 1'b0);
        checkOutput("rst_lsu_wins_tie", bus.lsu_ready, 1'b1);
        checkOutput("rst_exu_waits", bus.exu_ready, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd11, 64'hE11, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        expectWrite(5'd11, 64'hE11);
        #1;
        checkOutput("post_rst_exu_grant", bus.exu_ready, 1'b1);
        checkOutput("post_rst_rf_wen", bus.rf_wen, 1'b1);
        tick();
        idle(5'd0, 5'd0);
        #1;
        checkOutput("post_rst_last_wen", bus.rf_wen, 1'b1);
        tick();
        checkOutput("final_rf_wen_off", bus.rf_wen, 1'b0);
        tick();
        tick();
        checkOutput("queue_drained", exp_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
